// File: rtl/ieee1149_10_pkg.sv
// Shared constants and types for the IEEE1149.10 8b/10b lane monitors.
package ieee1149_10_pkg;

    localparam int unsigned SYM_W    = 10;
    localparam logic        RD_MINUS = 1'b1;
    localparam logic        RD_PLUS  = 1'b0;

    typedef enum logic {
        HUNT  = 1'b0,
        TRACK = 1'b1
    } lane_state_e;

endpackage

// File: rtl/rd_lane_chk.sv
// Single-lane 8b/10b checker: weight, running disparity, run length and
// a saturating error counter with a sticky flag.
module rd_lane_chk
    import ieee1149_10_pkg::*;
#(
    parameter int unsigned CNT_W         = 8,
    parameter int unsigned MAX_RUN       = 5,
    parameter bit          INIT_RD_KNOWN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sym_valid,
    input  logic [SYM_W-1:0] sym_in,
    input  logic             clr_err,
    output logic             rd_out,
    output logic             locked,
    output logic             disp_err,
    output logic             code_err,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_sticky
);

    localparam int unsigned RUN_W = $clog2(MAX_RUN + 1) + 1;
    localparam lane_state_e RST_STATE = INIT_RD_KNOWN ? TRACK : HUNT;

    function automatic logic [3:0] popcount(input logic [SYM_W-1:0] s);
        logic [3:0] n;
        n = '0;
        for (int unsigned i = 0; i < SYM_W; i++) begin
            n = n + {3'b000, s[i]};
        end
        return n;
    endfunction

    lane_state_e      state_q, state_d;
    logic             rd_q, rd_d;
    logic             disp_d, code_d;
    logic             disp_q, code_q;
    logic             last_q, last_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             run_viol;
    logic [3:0]       ones;
    logic             wt_ok;
    logic             sym_err;
    logic [CNT_W-1:0] cnt_q;
    logic             sticky_q;

    assign ones    = popcount(sym_in);
    assign wt_ok   = (ones >= 4'd4) && (ones <= 4'd6);
    assign sym_err = disp_d | code_d;

    // Walk the symbol bit 0 first, extending the run carried from the previous symbol.
    always_comb begin
        run_d    = run_q;
        last_d   = last_q;
        run_viol = 1'b0;
        for (int unsigned i = 0; i < SYM_W; i++) begin
            if (sym_in[i] == last_d) begin
                if (run_d != '1) begin
                    run_d = run_d + RUN_W'(1);
                end
            end else begin
                run_d = RUN_W'(1);
            end
            last_d = sym_in[i];
            if (run_d > RUN_W'(MAX_RUN)) begin
                run_viol = 1'b1;
            end
        end
    end

    // Next state, next RD and error pulses for the symbol on the input.
    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        disp_d  = 1'b0;
        code_d  = 1'b0;
        if (sym_valid) begin
            if (!wt_ok) begin
                code_d = 1'b1;
            end else begin
                unique case (state_q)
                    HUNT: begin
                        if (ones == 4'd6) begin
                            state_d = TRACK;
                            rd_d    = RD_PLUS;
                        end else if (ones == 4'd4) begin
                            state_d = TRACK;
                            rd_d    = RD_MINUS;
                        end
                    end
                    TRACK: begin
                        if (ones == 4'd6) begin
                            disp_d = (rd_q == RD_PLUS);
                            rd_d   = RD_PLUS;
                        end else if (ones == 4'd4) begin
                            disp_d = (rd_q == RD_MINUS);
                            rd_d   = RD_MINUS;
                        end
                    end
                    default: state_d = state_q;
                endcase
            end
            if (run_viol) begin
                code_d = 1'b1;
            end
        end
    end

    // Lane state, RD and registered error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            rd_q    <= RD_MINUS;
            disp_q  <= 1'b0;
            code_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            disp_q  <= disp_d;
            code_q  <= code_d;
        end
    end

    // Run tracker only advances on accepted symbols.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b0;
            run_q  <= '0;
        end else if (sym_valid) begin
            last_q <= last_d;
            run_q  <= run_d;
        end
    end

    // Saturating error counter and sticky flag; a clear still counts a concurrent error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else if (clr_err) begin
            cnt_q    <= sym_err ? CNT_W'(1) : '0;
            sticky_q <= sym_err;
        end else if (sym_err) begin
            if (cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            sticky_q <= 1'b1;
        end
    end

    assign rd_out     = rd_q;
    assign locked     = (state_q == TRACK);
    assign disp_err   = disp_q;
    assign code_err   = code_q;
    assign err_cnt    = cnt_q;
    assign err_sticky = sticky_q;

endmodule

// File: rtl/rd_lane_monitor.sv
// Multi-lane 8b/10b running-disparity and code-violation monitor.
module rd_lane_monitor
    import ieee1149_10_pkg::*;
#(
    parameter int unsigned NUM_LANES     = 1,
    parameter int unsigned CNT_W         = 8,
    parameter int unsigned MAX_RUN       = 5,
    parameter bit          INIT_RD_KNOWN = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_LANES-1:0]       sym_valid,
    input  logic [NUM_LANES*SYM_W-1:0] sym_in,
    input  logic                       clr_err,
    output logic [NUM_LANES-1:0]       rd_out,
    output logic [NUM_LANES-1:0]       locked,
    output logic [NUM_LANES-1:0]       disp_err,
    output logic [NUM_LANES-1:0]       code_err,
    output logic [NUM_LANES*CNT_W-1:0] err_cnt,
    output logic [NUM_LANES-1:0]       err_sticky
);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        rd_lane_chk #(
            .CNT_W         (CNT_W),
            .MAX_RUN       (MAX_RUN),
            .INIT_RD_KNOWN (INIT_RD_KNOWN)
        ) u_chk (
            .clk        (clk),
            .rst_n      (rst_n),
            .sym_valid  (sym_valid[i]),
            .sym_in     (sym_in[SYM_W*i +: SYM_W]),
            .clr_err    (clr_err),
            .rd_out     (rd_out[i]),
            .locked     (locked[i]),
            .disp_err   (disp_err[i]),
            .code_err   (code_err[i]),
            .err_cnt    (err_cnt[CNT_W*i +: CNT_W]),
            .err_sticky (err_sticky[i])
        );
    end

endmodule

// File: tb/tb_rd_lane_monitor.sv
// Scoreboard bench for rd_lane_monitor: three configurations driven in turn,
// expectations from a behavioural lane model pushed at drive time.
module tb_rd_lane_monitor;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT a: 1 lane, CNT_W=8, starts locked
    logic [0:0] va = '0;  logic [9:0]  sym_a = '0; logic ca = 1'b0;
    logic [0:0] rda, lka, dea, cea, sta; logic [7:0] cnta;
    // DUT b: 1 lane, CNT_W=2, starts locked
    logic [0:0] vb = '0;  logic [9:0]  sym_b = '0; logic cb = 1'b0;
    logic [0:0] rdb, lkb, deb, ceb, stb; logic [1:0] cntb;
    // DUT c: 2 lanes, CNT_W=8, starts hunting
    logic [1:0] vc = '0;  logic [19:0] sym_c = '0; logic cc = 1'b0;
    logic [1:0] rdc, lkc, dec, cec, stc; logic [15:0] cntc;

    rd_lane_monitor #(.NUM_LANES(1), .CNT_W(8), .MAX_RUN(5), .INIT_RD_KNOWN(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .sym_valid(va), .sym_in(sym_a), .clr_err(ca),
        .rd_out(rda), .locked(lka), .disp_err(dea), .code_err(cea), .err_cnt(cnta), .err_sticky(sta));
    rd_lane_monitor #(.NUM_LANES(1), .CNT_W(2), .MAX_RUN(5), .INIT_RD_KNOWN(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .sym_valid(vb), .sym_in(sym_b), .clr_err(cb),
        .rd_out(rdb), .locked(lkb), .disp_err(deb), .code_err(ceb), .err_cnt(cntb), .err_sticky(stb));
    rd_lane_monitor #(.NUM_LANES(2), .CNT_W(8), .MAX_RUN(5), .INIT_RD_KNOWN(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .sym_valid(vc), .sym_in(sym_c), .clr_err(cc),
        .rd_out(rdc), .locked(lkc), .disp_err(dec), .code_err(cec), .err_cnt(cntc), .err_sticky(stc));

    typedef struct {
        int   d;
        int   l;
        logic rd, lock, de, ce, st;
        int   cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    int lanes  [3] = '{1, 1, 2};
    int cnt_w  [3] = '{8, 2, 8};
    bit init_k [3] = '{1'b1, 1'b1, 1'b0};

    bit m_lock [3][2];
    bit m_rd   [3][2];
    bit m_last [3][2];
    int m_run  [3][2];
    int m_cnt  [3][2];
    bit m_st   [3][2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Symbols are written with the first-transmitted bit on the left.
    function automatic logic [9:0] rev(input logic [9:0] s);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = s[9-i];
        return r;
    endfunction

    function automatic exp_t observe(input int d, input int l);
        exp_t o;
        o.d = d; o.l = l;
        case (d)
            0: begin o.rd = rda[0]; o.lock = lka[0]; o.de = dea[0]; o.ce = cea[0]; o.st = sta[0]; o.cnt = int'(cnta); end
            1: begin o.rd = rdb[0]; o.lock = lkb[0]; o.de = deb[0]; o.ce = ceb[0]; o.st = stb[0]; o.cnt = int'(cntb); end
            default: begin
                o.rd = rdc[l]; o.lock = lkc[l]; o.de = dec[l]; o.ce = cec[l]; o.st = stc[l];
                o.cnt = int'(cntc[8*l +: 8]);
            end
        endcase
        return o;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++)
            for (int l = 0; l < 2; l++) begin
                m_lock[d][l] = init_k[d]; m_rd[d][l] = 1'b1; m_last[d][l] = 1'b0;
                m_run[d][l] = 0; m_cnt[d][l] = 0; m_st[d][l] = 1'b0;
            end
    endtask

    task automatic push_state(input int d, input int l, input bit de, input bit ce);
        exp_t e;
        e.d = d; e.l = l; e.rd = m_rd[d][l]; e.lock = m_lock[d][l];
        e.de = de; e.ce = ce; e.st = m_st[d][l]; e.cnt = m_cnt[d][l];
        sb.push_back(e);
    endtask

    task automatic push_all();
        for (int d = 0; d < 3; d++)
            for (int l = 0; l < lanes[d]; l++) push_state(d, l, 1'b0, 1'b0);
    endtask

    task automatic model_step(input int d, input int l, input bit v, input logic [9:0] s, input bit clr);
        int ones;
        bit de, ce, err;
        int mx;
        de = 1'b0; ce = 1'b0; ones = 0;
        if (v) begin
            for (int i = 0; i < 10; i++) begin
                ones += int'(s[i]);
                if (s[i] == m_last[d][l]) m_run[d][l] = (m_run[d][l] < 15) ? m_run[d][l] + 1 : 15;
                else m_run[d][l] = 1;
                m_last[d][l] = s[i];
                if (m_run[d][l] > 5) ce = 1'b1;
            end
            if (ones < 4 || ones > 6) ce = 1'b1;
            else if (!m_lock[d][l]) begin
                if (ones == 6)      begin m_lock[d][l] = 1'b1; m_rd[d][l] = 1'b0; end
                else if (ones == 4) begin m_lock[d][l] = 1'b1; m_rd[d][l] = 1'b1; end
            end else begin
                if (ones == 6)      begin if (!m_rd[d][l]) de = 1'b1; m_rd[d][l] = 1'b0; end
                else if (ones == 4) begin if (m_rd[d][l])  de = 1'b1; m_rd[d][l] = 1'b1; end
            end
        end
        err = de | ce;
        mx  = (1 << cnt_w[d]) - 1;
        if (clr) begin
            m_cnt[d][l] = err ? 1 : 0;
            m_st[d][l]  = err;
        end else if (err) begin
            if (m_cnt[d][l] < mx) m_cnt[d][l]++;
            m_st[d][l] = 1'b1;
        end
        push_state(d, l, de, ce);
    endtask

    task automatic drain_sb();
        exp_t e, o;
        string p;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = observe(e.d, e.l);
            p = $sformatf("d%0d_l%0d", e.d, e.l);
            check({p, "_rd"},     32'(o.rd),   32'(e.rd));
            check({p, "_locked"}, 32'(o.lock), 32'(e.lock));
            check({p, "_disp"},   32'(o.de),   32'(e.de));
            check({p, "_code"},   32'(o.ce),   32'(e.ce));
            check({p, "_sticky"}, 32'(o.st),   32'(e.st));
            check({p, "_cnt"},    32'(o.cnt),  32'(e.cnt));
        end
    endtask

    task automatic drive(input int d, input logic [1:0] v, input logic [19:0] s, input bit clr);
        va = '0; vb = '0; vc = '0; ca = 1'b0; cb = 1'b0; cc = 1'b0;
        case (d)
            0: begin va = v[0:0]; sym_a = s[9:0]; ca = clr; end
            1: begin vb = v[0:0]; sym_b = s[9:0]; cb = clr; end
            default: begin vc = v; sym_c = s; cc = clr; end
        endcase
        for (int l = 0; l < lanes[d]; l++) model_step(d, l, v[l], s[10*l +: 10], clr);
        @(posedge clk);
        #1;
        drain_sb();
    endtask

    int exp5 [5] = '{1, 2, 3, 3, 3};

    initial begin
        // Reset state of every configuration
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        push_all();
        drain_sb();
        check("rst_lock_c", 32'(lkc), 32'(2'b00));
        check("rst_rd_c",   32'(rdc), 32'(2'b11));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Legal alternating-disparity pair
        drive(0, 2'b01, {10'd0, rev(10'b0011111010)}, 1'b0);
        check("t1_rd_plus", 32'(rda), 32'(1'b0));
        drive(0, 2'b01, {10'd0, rev(10'b1100000101)}, 1'b0);
        check("t1_rd_minus", 32'(rda), 32'(1'b1));
        check("t1_cnt", 32'(cnta), 32'd0);

        // Disparity error at RD minus
        drive(0, 2'b01, {10'd0, rev(10'b1100000101)}, 1'b0);
        check("t2_disp", 32'(dea), 32'(1'b1));
        check("t2_cnt", 32'(cnta), 32'd1);
        drive(0, 2'b00, 20'd0, 1'b0);
        check("t2_pulse_end", 32'(dea), 32'(1'b0));

        // Illegal weight, then clean symbol
        drive(0, 2'b01, {10'd0, rev(10'b0000000000)}, 1'b0);
        check("t3_code", 32'(cea), 32'(1'b1));
        check("t3_rd", 32'(rda), 32'(1'b1));
        drive(0, 2'b01, {10'd0, rev(10'b1010101010)}, 1'b0);
        check("t3_clean", 32'(cea), 32'(1'b0));

        // Run crossing a symbol boundary
        drive(0, 2'b01, {10'd0, rev(10'b1111100000)}, 1'b0);
        check("t4_first", 32'(cea), 32'(1'b0));
        drive(0, 2'b01, {10'd0, rev(10'b0000011111)}, 1'b0);
        check("t4_run", 32'(cea), 32'(1'b1));
        check("t4_cnt", 32'(cnta), 32'd3);

        // Random traffic on the single-lane monitor
        for (int i = 0; i < 60; i++)
            drive(0, 2'($urandom), 20'($urandom), ($urandom_range(0, 15) == 0));

        // Counter saturation with CNT_W=2
        for (int i = 0; i < 5; i++) begin
            drive(1, 2'b01, 20'd0, 1'b0);
            check("t5_cnt", 32'(cntb), 32'(exp5[i]));
        end
        drive(1, 2'b01, 20'd0, 1'b1);
        check("t5_clr_err", 32'(cntb), 32'd1);
        drive(1, 2'b00, 20'd0, 1'b1);
        check("t5_clr", 32'(cntb), 32'd0);

        // Hunt lock on lane 0, lane 1 idle
        for (int i = 0; i < 3; i++) begin
            drive(2, 2'b01, {10'd0, rev(10'b1010101010)}, 1'b0);
            check("t6_hunt", 32'(lkc[0]), 32'(1'b0));
        end
        drive(2, 2'b01, {10'd0, rev(10'b0011111010)}, 1'b0);
        check("t6_lock", 32'(lkc[0]), 32'(1'b1));
        check("t6_rd", 32'(rdc[0]), 32'(1'b0));
        check("t6_l1_hold", 32'(lkc[1]), 32'(1'b0));
        drive(2, 2'b10, {rev(10'b1100000101), 10'd0}, 1'b0);
        check("t6_l1_lock", 32'(lkc[1]), 32'(1'b1));
        for (int i = 0; i < 40; i++)
            drive(2, 2'($urandom), 20'($urandom), ($urandom_range(0, 15) == 0));

        // Asynchronous reset in the middle of traffic
        va = '0; vb = '0; ca = 1'b0; cb = 1'b0; cc = 1'b0;
        vc = 2'b11;
        sym_c = {rev(10'b0000000000), rev(10'b0011111010)};
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        push_all();
        drain_sb();
        check("t6_rst_lock", 32'(lkc), 32'(2'b00));
        @(posedge clk); #1;
        push_all();
        drain_sb();
        vc = '0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive(2, 2'b01, {10'd0, rev(10'b0011111010)}, 1'b0);
        check("t6_relock", 32'(lkc[0]), 32'(1'b1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
